sprite_anim_renderer: RTL and testbench
=======================================

Name: sprite_anim_renderer

Overview:
- Parametrised successor to the single-character sprite drawer.
- Renders one movable sprite at (CharX, CharY), with:
  - multiple animation frames stored back-to-back in one external sync ROM;
  - horizontal flip;
  - colour-key transparency;
  - a frame-sequencing FSM stepped by a per-frame tick.
- Sits between the VGA timing/position logic and the layer-priority mux.
- Two instances (player 1 and player 2) replace the per-character modules.

Parameters:
- SPR_W, 40, sprite width in pixels (1..63).
- SPR_H, 50, sprite height in pixels (1..63).
- FRAMES, 4, animation frames in ROM (1..16).
- IDX_W, 3, palette index width.
- TRANSP_IDX, 0, palette index treated as transparent.
- FRAME_HOLD, 8, frame_tick pulses per animation frame (1..255).
- ADDR_W, $clog2(FRAMES*SPR_W*SPR_H), ROM address width (derived, do not override).

Ports:
- vga_clk  in  1  pixel clock; all state on posedge.
- reset  in  1  synchronous, active-high.
- DrawX, DrawY  in  10 each  current pixel.
- CharX, CharY  in  10 each  sprite top-left; may be placed so the sprite extends past 639/479.
- blank  in  1  1 = visible region.
- frame_tick  in  1  one-cycle pulse per video frame (start of vblank).
- anim_en  in  1  level; 1 = run the animation.
- one_shot  in  1  sampled on IDLE→PLAY; 1 = play once, 0 = loop.
- flip_h  in  1  mirror horizontally; sampled per pixel.
- rom_addr  out  ADDR_W  address to the external sync ROM (1-cycle read latency, posedge).
- rom_q  in  IDX_W  ROM data.
- red_out, green_out, blue_out  out  4 each  pixel colour.
- active  out  1  sprite covers this pixel (non-transparent).
- anim_done  out  1  high while in DONE.

Behaviour:
Reset values:
- red_out = green_out = blue_out = 0.
- active = 0, anim_done = 0.
- frame = 0, hold_cnt = 0, state = IDLE.
- Pipeline valid bits cleared.

Hit test (11-bit arithmetic, no wrap):
- hit = (DrawX >= CharX) && (DrawX < CharX+SPR_W) && (DrawY >= CharY) && (DrawY < CharY+SPR_H).

Address (combinational from the current inputs):
- sx = DrawX-CharX, sy = DrawY-CharY.
- col = flip_h ? SPR_W-1-sx : sx.
- rom_addr = frame*SPR_W*SPR_H + sy*SPR_W + col.
- When !hit, rom_addr is don't-care; it must not be used.

Pipeline:
- Stage 1 registers hit && blank alongside the ROM read.
- Stage 2 registers the outputs.
- Latency is exactly 2 vga_clk from DrawX/DrawY to red/green/blue/active.

Stage 2 outputs:
- If stage-1 valid && rom_q != TRANSP_IDX: outputs = palette(rom_q), active = 1.
- Otherwise: outputs = 0, active = 0.

FSM (frame and hold_cnt change only on a frame_tick cycle, so no mid-frame tearing, with one exception: anim_en falling resets frame immediately):
- IDLE: frame = 0.
  - anim_en = 1 → PLAY, latching one_shot; hold_cnt = 0.
  - A frame_tick in the same cycle does not advance the frame.
- PLAY, on frame_tick: hold_cnt++.
  - When hold_cnt == FRAME_HOLD-1: hold_cnt = 0 and the frame advances.
  - Frame FRAMES-1 → 0 when looping.
  - Frame FRAMES-1 → DONE when one-shot; frame stays at FRAMES-1.
- DONE: frame held at FRAMES-1; anim_done = 1.
- Any state with anim_en = 0 → IDLE next cycle; frame = 0, hold_cnt = 0.
- FRAMES = 1: PLAY never changes frame; a one-shot reaches DONE after FRAME_HOLD ticks.
- Reset mid-animation: returns to IDLE, frame 0; the output pipeline is flushed (2 cycles of zeros).

Optional Feature:
- Macro: SPRITE_BBOX_EN.
- Defined: on blank pixels where hit && (sx==0 || sx==SPR_W-1 || sy==0 || sy==SPR_H-1), output is 4'hF, 4'h0, 4'h0 with active = 1, overriding transparency. Same 2-cycle latency.
- Undefined: no outline logic; behaviour exactly as above.

Decomposition:
- Package sprite_pkg:
  - typedef anim_state_e {IDLE, PLAY, DONE};
  - typedef rgb444_t (struct r, g, b 4-bit);
  - localparam SCREEN_W = 640, SCREEN_H = 480.
- Sub-module sprite_palette: combinational index → rgb444_t, contents per character.
- FSM and pipeline stay in the top module.

Test Plan:
1. Reset, then CharX=100, CharY=200, frame 0, ROM fill = addr%8 (so TRANSP_IDX=0 falls on every 8th address). Sweep DrawX=100..139 at DrawY=200, blank=1 → active follows rom_q!=0 with 2-cycle latency; active=0 at DrawX=99 and 140.
2. flip_h=1, same scan → rom_addr at DrawX=100 is 39, at DrawX=139 is 0.
3. anim_en=1, one_shot=0, FRAME_HOLD=2, FRAMES=4. Give 8 frame_ticks → frame sequence 0,0,1,1,2,2,3,3, then wrap to 0. rom_addr base = 2000 while frame=1.
4. one_shot=1 → after 8 ticks, state DONE, anim_done=1, frame=3. Deassert anim_en → anim_done=0 and frame=0 next cycle.
5. Simultaneous anim_en rise and frame_tick → frame stays 0 for that tick. Reset asserted mid-PLAY at frame 2 → frame=0, outputs 0 for 2 cycles.
6. CharX=620 (sprite past the right edge) → hit for DrawX=620..639 only, no wrap to DrawX=0..19. blank=0 inside the box → active=0.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types, screen constants and per-character palettes for the animated sprite renderer.
package sprite_pkg;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;

   typedef enum logic [1:0] {IDLE, PLAY, DONE} anim_state_e;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;

   // 12-bit RGB444 entries; index 0 is the colour-key slot and is never shown.
   localparam logic [11:0] PAL_P1 [8] = '{12'h000, 12'hFC9, 12'h24C, 12'hFFF,
                                          12'h841, 12'hC11, 12'h111, 12'hFE2};
   localparam logic [11:0] PAL_P2 [8] = '{12'h000, 12'hEB8, 12'hC22, 12'hFFF,
                                          12'h321, 12'h282, 12'h111, 12'h99F};

endpackage

// File: rtl/sprite_palette.sv
// Combinational palette index to RGB444 lookup; PALETTE_SEL picks player 1 or player 2 colours.
module sprite_palette
   import sprite_pkg::*;
#(
   parameter int IDX_W       = 3,
   parameter int PALETTE_SEL = 0
)(
   input  logic [IDX_W-1:0] idx,
   output rgb444_t          rgb
);

   localparam int N_ENT = 1 << IDX_W;

   rgb444_t lut [N_ENT];

   // Wider index spaces repeat the 8-entry base palette.
   genvar gi;
   for (gi = 0; gi < N_ENT; gi++) begin : g_lut
      assign lut[gi] = (PALETTE_SEL == 0) ? rgb444_t'(PAL_P1[gi % 8]) : rgb444_t'(PAL_P2[gi % 8]);
   end

   assign rgb = lut[idx];

endmodule

// File: rtl/sprite_anim_renderer.sv
// Animated, flippable, colour-keyed sprite renderer with a 2-cycle pixel pipeline.
// Optional debug outline around the sprite box when SPRITE_BBOX_EN is defined.
module sprite_anim_renderer
   import sprite_pkg::*;
#(
   parameter int SPR_W       = 40,
   parameter int SPR_H       = 50,
   parameter int FRAMES      = 4,
   parameter int IDX_W       = 3,
   parameter int TRANSP_IDX  = 0,
   parameter int FRAME_HOLD  = 8,
   parameter int PALETTE_SEL = 0,
   parameter int ADDR_W      = $clog2(FRAMES*SPR_W*SPR_H)
)(
   input  logic              vga_clk,
   input  logic              reset,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   input  logic [9:0]        CharX,
   input  logic [9:0]        CharY,
   input  logic              blank,
   input  logic              frame_tick,
   input  logic              anim_en,
   input  logic              one_shot,
   input  logic              flip_h,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [IDX_W-1:0]  rom_q,
   output logic [3:0]        red_out,
   output logic [3:0]        green_out,
   output logic [3:0]        blue_out,
   output logic              active,
   output logic              anim_done
);

   localparam int         FRAME_SZ   = SPR_W * SPR_H;
   localparam logic [3:0] LAST_FRAME = 4'(FRAMES - 1);
   localparam logic [7:0] LAST_HOLD  = 8'(FRAME_HOLD - 1);

   anim_state_e state_reg, state_next;
   logic [3:0]  frame_reg, frame_next;
   logic [7:0]  hold_reg, hold_next;
   logic        one_shot_reg, one_shot_next;

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         frame_reg    <= '0;
         hold_reg     <= '0;
         one_shot_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         frame_reg    <= frame_next;
         hold_reg     <= hold_next;
         one_shot_reg <= one_shot_next;
      end
   end

   // Frame only moves on frame_tick; dropping anim_en is the sole immediate rewind.
   always_comb begin
      state_next    = state_reg;
      frame_next    = frame_reg;
      hold_next     = hold_reg;
      one_shot_next = one_shot_reg;
      if (!anim_en) begin
         state_next = IDLE;
         frame_next = '0;
         hold_next  = '0;
      end else begin
         case (state_reg)
            IDLE: begin
               state_next    = PLAY;
               frame_next    = '0;
               hold_next     = '0;
               one_shot_next = one_shot;
            end
            PLAY: begin
               if (frame_tick) begin
                  if (hold_reg == LAST_HOLD) begin
                     hold_next = '0;
                     if (frame_reg == LAST_FRAME) begin
                        if (one_shot_reg) state_next = DONE;
                        else              frame_next = '0;
                     end else begin
                        frame_next = frame_reg + 4'd1;
                     end
                  end else begin
                     hold_next = hold_reg + 8'd1;
                  end
               end
            end
            DONE:    frame_next = LAST_FRAME;
            default: state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      anim_done = (state_reg == DONE);
   end

   // 11-bit compares so a sprite hanging off the right/bottom edge never wraps.
   logic [10:0] dx, dy, cx, cy, sx, sy, col;
   logic        hit;

   assign dx  = {1'b0, DrawX};
   assign dy  = {1'b0, DrawY};
   assign cx  = {1'b0, CharX};
   assign cy  = {1'b0, CharY};
   assign hit = (dx >= cx) && (dx < cx + 11'(SPR_W)) && (dy >= cy) && (dy < cy + 11'(SPR_H));
   assign sx  = dx - cx;
   assign sy  = dy - cy;
   assign col = flip_h ? (11'(SPR_W - 1) - sx) : sx;

   assign rom_addr = ADDR_W'(32'(frame_reg) * 32'(FRAME_SZ) + 32'(sy) * 32'(SPR_W) + 32'(col));

   logic    valid1_reg;
   logic    outline;
   rgb444_t pix_rgb;
   rgb444_t rgb_next;
   logic    active_next;

   sprite_palette #(
      .IDX_W       (IDX_W),
      .PALETTE_SEL (PALETTE_SEL)
   ) u_palette (
      .idx (rom_q),
      .rgb (pix_rgb)
   );

`ifdef SPRITE_BBOX_EN
   logic edge_reg;

   always_ff @(posedge vga_clk) begin
      if (reset) edge_reg <= 1'b0;
      else       edge_reg <= hit && ((sx == 11'd0) || (sx == 11'(SPR_W - 1)) ||
                                     (sy == 11'd0) || (sy == 11'(SPR_H - 1)));
   end

   assign outline = valid1_reg && edge_reg;
`else
   assign outline = 1'b0;
`endif

   always_comb begin
      rgb_next    = '0;
      active_next = 1'b0;
      if (outline) begin
         rgb_next    = rgb444_t'(12'hF00);
         active_next = 1'b1;
      end else if (valid1_reg && (rom_q != IDX_W'(TRANSP_IDX))) begin
         rgb_next    = pix_rgb;
         active_next = 1'b1;
      end
   end

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         valid1_reg <= 1'b0;
         red_out    <= '0;
         green_out  <= '0;
         blue_out   <= '0;
         active     <= 1'b0;
      end else begin
         valid1_reg <= hit && blank;
         red_out    <= rgb_next.r;
         green_out  <= rgb_next.g;
         blue_out   <= rgb_next.b;
         active     <= active_next;
      end
   end

endmodule

// File: tb/tb_sprite_anim_renderer.sv
// Randomised + directed bench for sprite_anim_renderer against a tick-count animation model.
module tb_sprite_anim_renderer;

   localparam int W    = 40;
   localparam int H    = 50;
   localparam int F    = 4;
   localparam int HOLD = 2;
   localparam int AW   = 13;

   logic          vga_clk = 1'b0;
   logic          reset = 1'b1;
   logic [9:0]    DrawX = '0, DrawY = '0, CharX = '0, CharY = '0;
   logic          blank = 1'b0, frame_tick = 1'b0, anim_en = 1'b0, one_shot = 1'b0, flip_h = 1'b0;
   logic [AW-1:0] rom_addr;
   logic [2:0]    rom_q;
   logic [3:0]    red_out, green_out, blue_out;
   logic          active, anim_done;

   always #5 vga_clk = ~vga_clk;

   sprite_anim_renderer #(.FRAME_HOLD(HOLD)) dut (
      .vga_clk    (vga_clk),
      .reset      (reset),
      .DrawX      (DrawX),
      .DrawY      (DrawY),
      .CharX      (CharX),
      .CharY      (CharY),
      .blank      (blank),
      .frame_tick (frame_tick),
      .anim_en    (anim_en),
      .one_shot   (one_shot),
      .flip_h     (flip_h),
      .rom_addr   (rom_addr),
      .rom_q      (rom_q),
      .red_out    (red_out),
      .green_out  (green_out),
      .blue_out   (blue_out),
      .active     (active),
      .anim_done  (anim_done)
   );

   logic [2:0] rom_mem [8192];
   always @(posedge vga_clk) rom_q <= rom_mem[rom_addr];

   int pal [8] = '{'h000, 'hFC9, 'h24C, 'hFFF, 'h841, 'hC11, 'h111, 'hFE2};

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Animation model: count accepted ticks since PLAY began and derive the frame from it.
   int m_play = 0, m_t = 0, m_os = 0;

   function automatic int m_frame();
      int f;
      if (m_play == 0) return 0;
      f = m_t / HOLD;
      if (m_os != 0) return (f > F - 1) ? F - 1 : f;
      return f % F;
   endfunction

   bit chk_en = 1'b0;
   bit exp_hit = 1'b0;
   int exp_addr = 0, exp_done = 0;
   int exp_out = 0, exp_act = 0;
   int d1_col = 0, d1_act = 0, cur_col = 0, cur_act = 0;

   task automatic half();
      int sx, sy, col, idx;
      exp_hit = (int'(DrawX) >= int'(CharX)) && (int'(DrawX) < int'(CharX) + W) &&
                (int'(DrawY) >= int'(CharY)) && (int'(DrawY) < int'(CharY) + H);
      cur_col = 0;
      cur_act = 0;
      if (exp_hit) begin
         sx  = int'(DrawX) - int'(CharX);
         sy  = int'(DrawY) - int'(CharY);
         col = flip_h ? W - 1 - sx : sx;
         exp_addr = m_frame() * W * H + sy * W + col;
         if (blank) begin
            idx = int'(rom_mem[exp_addr]);
            if (idx != 0) begin
               cur_act = 1;
               cur_col = pal[idx];
            end
         end
      end
      exp_done = (m_play != 0 && m_os != 0 && m_t >= F * HOLD) ? 1 : 0;
      @(negedge vga_clk);
      #1;
   endtask

   task automatic adv();
      @(posedge vga_clk);
      if (reset) begin
         m_play = 0; m_t = 0;
         exp_out = 0; exp_act = 0; d1_col = 0; d1_act = 0;
      end else begin
         exp_out = d1_col; exp_act = d1_act;
         d1_col  = cur_col; d1_act = cur_act;
         if (!anim_en) m_play = 0;
         else if (m_play == 0) begin m_play = 1; m_t = 0; m_os = one_shot ? 1 : 0; end
         else if (frame_tick) m_t++;
      end
      #1;
   endtask

   task automatic cycle();
      half();
      adv();
   endtask

   always @(negedge vga_clk) begin
      if (chk_en) begin
         if (exp_hit) chk("rom_addr", 32'(rom_addr), exp_addr);
         chk("rgb", {20'd0, red_out, green_out, blue_out}, exp_out);
         chk("active", 32'(active), exp_act);
         chk("anim_done", 32'(anim_done), exp_done);
      end
   end

   initial begin
      for (int a = 0; a < 8192; a++) rom_mem[a] = 3'(a % 8);
      adv();
      chk_en = 1'b1;
      half();
      chk("reset_rgb", {20'd0, red_out, green_out, blue_out}, 0);
      chk("reset_active", 32'(active), 0);
      chk("reset_done", 32'(anim_done), 0);
      adv();
      reset = 1'b0;
      $display("txn: reset done");

      CharX = 10'd100; CharY = 10'd200; DrawY = 10'd200; blank = 1'b1;
      for (int x = 98; x <= 142; x++) begin
         DrawX = 10'(x);
         half();
         if (x == 100) chk("addr_x100", 32'(rom_addr), 0);
         if (x == 102) chk("act_x100_transp", 32'(active), 0);
         if (x == 103) begin
            chk("act_x101", 32'(active), 1);
            chk("rgb_x101", {20'd0, red_out, green_out, blue_out}, 32'h0FC9);
         end
         if (x == 141) chk("act_x139", 32'(active), 1);
         if (x == 142) chk("act_x140", 32'(active), 0);
         adv();
      end
      $display("txn: plain scan 98..142");

      flip_h = 1'b1;
      for (int x = 100; x <= 139; x++) begin
         DrawX = 10'(x);
         half();
         if (x == 100) chk("flip_addr_x100", 32'(rom_addr), 39);
         if (x == 139) chk("flip_addr_x139", 32'(rom_addr), 0);
         adv();
      end
      flip_h = 1'b0;
      $display("txn: flipped scan 100..139");

      DrawX = 10'd100; anim_en = 1'b1; one_shot = 1'b0;
      cycle();
      for (int k = 1; k <= 8; k++) begin
         frame_tick = 1'b1; cycle(); frame_tick = 1'b0;
         half();
         if (k == 2) chk("loop_frame1_base", 32'(rom_addr), 2000);
         if (k == 7) chk("loop_frame3_base", 32'(rom_addr), 6000);
         if (k == 8) chk("loop_wrap", 32'(rom_addr), 0);
         adv();
      end
      $display("txn: looping animation, 8 ticks");

      anim_en = 1'b0; cycle();
      anim_en = 1'b1; one_shot = 1'b1; cycle();
      for (int k = 1; k <= 8; k++) begin
         frame_tick = 1'b1; cycle(); frame_tick = 1'b0; cycle();
      end
      half();
      chk("oneshot_done", 32'(anim_done), 1);
      chk("oneshot_last_frame", 32'(rom_addr), 6000);
      adv();
      anim_en = 1'b0;
      cycle();
      half();
      chk("disable_done", 32'(anim_done), 0);
      chk("disable_frame0", 32'(rom_addr), 0);
      adv();
      $display("txn: one-shot animation and disable");

      anim_en = 1'b1; one_shot = 1'b0; frame_tick = 1'b1;
      cycle();
      cycle();
      frame_tick = 1'b0;
      half();
      chk("start_tick_ignored", 32'(rom_addr), 0);
      adv();
      for (int k = 0; k < 3; k++) begin
         frame_tick = 1'b1; cycle(); frame_tick = 1'b0; cycle();
      end
      DrawX = 10'd103;
      half();
      chk("pre_reset_frame2", 32'(rom_addr), 4003);
      adv();
      cycle();
      reset = 1'b1; cycle(); reset = 1'b0;
      half();
      chk("post_reset_addr", 32'(rom_addr), 3);
      chk("post_reset_act0", 32'(active), 0);
      adv();
      half();
      chk("post_reset_act1", 32'(active), 0);
      adv();
      $display("txn: start/tick collision and mid-play reset");

      anim_en = 1'b0; CharX = 10'd620; CharY = 10'd200; DrawY = 10'd210;
      for (int x = 0; x < 640; x++) begin
         DrawX = 10'(x);
         half();
         if (x == 12) chk("edge_nowrap_act", 32'(active), 0);
         if (x == 620) chk("edge_addr_x620", 32'(rom_addr), 400);
         if (x == 623) chk("edge_act_x621", 32'(active), 1);
         if (x == 639) chk("edge_addr_x639", 32'(rom_addr), 419);
         adv();
      end
      DrawX = 10'd625; blank = 1'b0;
      cycle(); cycle();
      half();
      chk("blank_inside_act", 32'(active), 0);
      adv();
      $display("txn: right-edge scan and blanking");

      for (int a = 0; a < 8192; a++) rom_mem[a] = 3'($urandom_range(0, 7));
      for (int n = 0; n < 4000; n++) begin
         int cxv, cyv;
         DrawX = 10'($urandom_range(0, 639));
         DrawY = 10'($urandom_range(0, 479));
         cxv = int'(DrawX) - int'($urandom_range(0, 45));
         cyv = int'(DrawY) - int'($urandom_range(0, 55));
         CharX = 10'((cxv < 0) ? 0 : cxv);
         CharY = 10'((cyv < 0) ? 0 : cyv);
         blank      = ($urandom_range(0, 7) != 0);
         flip_h     = $urandom_range(0, 1) != 0;
         one_shot   = $urandom_range(0, 1) != 0;
         frame_tick = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 60) == 0) anim_en = ~anim_en;
         reset = ($urandom_range(0, 250) == 0);
         cycle();
      end
      reset = 1'b0;
      $display("txn: random phase 4000 cycles");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
